// File: rtl/vscpu_loader.sv
// Stream loader for the VSCPU block RAM: writes header-described records into RAM while holding
// the CPU in reset, then hands the RAM port to the CPU and releases its reset.
module vscpu_loader #(
  parameter int unsigned SIZE  = 14,
  parameter int unsigned DEPTH = 2 ** SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic            cpu_wrEn,
  input  logic [SIZE-1:0] cpu_addr,
  input  logic [31:0]     cpu_data,
  output logic            ram_wrEn,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_data,
  output logic            cpu_rst,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {StHdr, StData, StRun} state_e;

  state_e          r_state;
  logic [SIZE-1:0] r_addr_cnt;
  logic [SIZE-1:0] r_words_left;
  logic            r_last_flag;
  logic            r_cpu_rst;
  logic            r_done;
  logic            r_err;

  logic            w_xfer;
  logic            w_hdr_bad;
  logic            w_hdr_last;
  logic [SIZE-1:0] w_hdr_count;
  logic [SIZE-1:0] w_hdr_base;
  logic [SIZE:0]   w_addr_inc;
  logic [SIZE-1:0] w_addr_next;

  // Header: [31] LAST, [30:2*SIZE] reserved, [2*SIZE-1:SIZE] COUNT, [SIZE-1:0] BASE
  assign w_hdr_last  = in_data[31];
  assign w_hdr_bad   = |in_data[30:2*SIZE];
  assign w_hdr_count = in_data[2*SIZE-1:SIZE];
  assign w_hdr_base  = in_data[SIZE-1:0];

  assign w_addr_inc  = {1'b0, r_addr_cnt} + {{SIZE{1'b0}}, 1'b1};
  assign w_addr_next = (32'(w_addr_inc) >= DEPTH) ? '0 : w_addr_inc[SIZE-1:0];

  assign w_xfer  = in_valid & in_ready;
  assign cpu_rst = r_cpu_rst;
  assign done    = r_done;
  assign err     = r_err;

  always_comb begin
    in_ready = ~rst & (r_state != StRun);
    ram_wrEn = 1'b0;
    ram_addr = r_addr_cnt;
    ram_data = in_data;
    unique case (r_state)
      StData: ram_wrEn = in_valid;
      StRun: begin
        ram_wrEn = cpu_wrEn;
        ram_addr = cpu_addr;
        ram_data = cpu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StHdr;
      r_addr_cnt   <= '0;
      r_words_left <= '0;
      r_last_flag  <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Lags RUN entry by one edge so the CPU sees one RUN cycle still in reset
      r_cpu_rst <= (r_state != StRun);
      unique case (r_state)
        StHdr: begin
          if (w_xfer) begin
            if (w_hdr_bad) begin
              r_err <= 1'b1;
            end else begin
              r_addr_cnt   <= w_hdr_base;
              r_words_left <= w_hdr_count;
              r_last_flag  <= w_hdr_last;
              if (w_hdr_count != '0) begin
                r_state <= StData;
              end else if (w_hdr_last) begin
                r_state <= StRun;
                r_done  <= 1'b1;
              end
            end
          end
        end
        StData: begin
          if (w_xfer) begin
            r_addr_cnt   <= w_addr_next;
            r_words_left <= r_words_left - {{(SIZE-1){1'b0}}, 1'b1};
            if (r_words_left == {{(SIZE-1){1'b0}}, 1'b1}) begin
              if (r_last_flag) begin
                r_state <= StRun;
                r_done  <= 1'b1;
              end else begin
                r_state <= StHdr;
              end
            end
          end
        end
        StRun: ;
        default: r_state <= StHdr;
      endcase
    end
  end

endmodule

// File: tb/tb_vscpu_loader.sv
// Bench for vscpu_loader: behavioural record-stream model plus an external RAM, checked every
// cycle, with directed scenarios and randomized record streams.
module tb_vscpu_loader;

  localparam int unsigned SIZE  = 14;
  localparam int unsigned DEPTH = 2 ** SIZE;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_data = '0;
  logic            cpu_wrEn = 1'b0;
  logic [SIZE-1:0] cpu_addr = '0;
  logic [31:0]     cpu_data = '0;
  logic            ram_wrEn;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_data;
  logic            cpu_rst;
  logic            done;
  logic            err;

  vscpu_loader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .cpu_wrEn (cpu_wrEn),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .ram_wrEn (ram_wrEn),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  bit noise  = 1'b0;

  logic [31:0] ram     [DEPTH];
  logic [31:0] exp_mem [DEPTH];

  // Block RAM seen by the loader
  always @(posedge clk) begin
    if (ram_wrEn) begin
      ram[ram_addr] <= ram_data;
      n_wr++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = expecting header, 1 = inside a record, 2 = CPU owns RAM
  int m_phase, m_base, m_idx, m_count;
  bit m_last, m_err, m_cpu_rst, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_base = 0; m_idx = 0; m_count = 0;
      m_last = 0; m_err = 0; m_cpu_rst = 1; m_done = 0;
    end else begin
      m_cpu_rst = (m_phase != 2);
      case (m_phase)
        0: if (in_valid) begin
          if (in_data[30:28] != 3'b000) m_err = 1;
          else begin
            m_base  = int'(in_data[13:0]);
            m_count = int'(in_data[27:14]);
            m_idx   = 0;
            m_last  = in_data[31];
            if (m_count != 0) m_phase = 1;
            else if (m_last) m_phase = 2;
          end
        end
        1: if (in_valid) begin
          exp_mem[(m_base + m_idx) % DEPTH] = in_data;
          m_idx++;
          if (m_idx == m_count) m_phase = m_last ? 2 : 0;
        end
        default: if (cpu_wrEn) exp_mem[cpu_addr] = cpu_data;
      endcase
      m_done = (m_phase == 2);
    end
  end

  // Per-cycle comparison away from the active edge
  always @(negedge clk) begin
    logic [31:0] e_addr;
    e_addr = (m_phase == 2) ? 32'(cpu_addr) : 32'((m_base + m_idx) % DEPTH);
    chk("in_ready", 32'(in_ready), 32'(!rst && m_phase != 2));
    chk("ram_wrEn", 32'(ram_wrEn),
        32'((m_phase == 2) ? cpu_wrEn : (m_phase == 1) ? in_valid : 1'b0));
    chk("ram_addr", 32'(ram_addr), e_addr);
    chk("ram_data", ram_data, (m_phase == 2) ? cpu_data : in_data);
    chk("cpu_rst", 32'(cpu_rst), 32'(m_cpu_rst));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  end

  // Present one word with an optional leading bubble; bounded wait for acceptance
  task automatic push(input logic [31:0] w, input int gap);
    int  n = 0;
    bit  got = 0;
    repeat (gap) begin
      in_valid = 1'b0; in_data = $urandom;
      cpu_wrEn = noise & $urandom_range(1, 0); cpu_addr = SIZE'($urandom); cpu_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = w;
    while (!got && n < 50) begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_data = $urandom;
    cpu_wrEn = 1'b0;
    if (!got) chk("push_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic sweep(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic basic_stream(input int gap);
    push(32'h0000_8000, 0);
    push(32'h0019_0065, gap);
    push(32'h1019_0003, gap);
    push(32'h8000_8064, gap);
    push(32'h0000_0005, gap);
    push(32'h0000_000A, gap);
  endtask

  initial begin
    logic [31:0] w;
    int nrec, cnt, wr0;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; exp_mem[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic load then run
    wr0 = n_wr;
    basic_stream(0);
    chk("basic_done_edge", 32'(done), 32'd1);
    chk("basic_cpu_rst_still_high", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1;
    chk("basic_cpu_rst_low", 32'(cpu_rst), 32'd0);
    chk("basic_ram0", ram[0], 32'h0019_0065);
    chk("basic_ram1", ram[1], 32'h1019_0003);
    chk("basic_ram100", ram[100], 32'd5);
    chk("basic_ram101", ram[101], 32'd10);
    chk("basic_sum", ram[100] + ram[101], 32'd15);
    chk("basic_writes", 32'(n_wr - wr0), 32'd4);
    sweep("basic_sweep");

    // Backpressure: in_valid low on alternate cycles
    do_reset();
    wr0 = n_wr;
    basic_stream(1);
    chk("bp_writes", 32'(n_wr - wr0), 32'd4);
    chk("bp_ram100", ram[100], 32'd5);
    sweep("bp_sweep");

    // Address wrap
    do_reset();
    push(32'h8000_BFFF, 0);
    push(32'hAAAA_0001, 0);
    push(32'hAAAA_0002, 0);
    chk("wrap_top", ram[16383], 32'hAAAA_0001);
    chk("wrap_zero", ram[0], 32'hAAAA_0002);
    chk("wrap_done", 32'(done), 32'd1);

    // Malformed then empty last header
    do_reset();
    wr0 = n_wr;
    push(32'h1000_0000, 0);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_ready", 32'(in_ready), 32'd1);
    push(32'h8000_0000, 0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_err_sticky", 32'(err), 32'd1);
    chk("empty_writes", 32'(n_wr - wr0), 32'd0);

    // Reset mid-load
    do_reset();
    push(32'h8001_4000, 0);
    push(32'h0000_0011, 0);
    push(32'h0000_0022, 0);
    do_reset();
    push(32'h8000_4005, 0);
    push(32'h0000_0033, 0);
    chk("mid_ram0", ram[0], 32'h11);
    chk("mid_ram1", ram[1], 32'h22);
    chk("mid_ram2", ram[2], 32'h0);
    chk("mid_ram4", ram[4], 32'h0);
    chk("mid_ram5", ram[5], 32'h33);
    @(posedge clk); #1;

    // RUN isolation
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    cpu_wrEn = 1'b1; cpu_addr = 14'd7; cpu_data = 32'h1234_5678;
    #1;
    chk("iso_ready", 32'(in_ready), 32'd0);
    chk("iso_addr", 32'(ram_addr), 32'd7);
    chk("iso_data", ram_data, 32'h1234_5678);
    @(posedge clk); #1;
    cpu_wrEn = 1'b0; in_valid = 1'b0;
    chk("iso_ram7", ram[7], 32'h1234_5678);
    sweep("iso_sweep");

    // Randomized record streams with bubbles, bad headers and CPU noise
    for (int t = 0; t < 12; t++) begin
      do_reset();
      noise = 1'b1;
      nrec = $urandom_range(4, 1);
      for (int r = 0; r < nrec; r++) begin
        cnt = $urandom_range(6, 0);
        w = {(r == nrec - 1), 3'b000, cnt[13:0], 14'($urandom)};
        if ($urandom_range(7, 0) == 0) w[30:28] = 3'($urandom_range(7, 1));
        push(w, $urandom_range(2, 0));
        if (w[30:28] == 3'b000)
          for (int k = 0; k < cnt; k++) push($urandom, $urandom_range(2, 0));
      end
      noise = 1'b0;
      repeat (20) begin
        cpu_wrEn = $urandom_range(1, 0); cpu_addr = SIZE'($urandom); cpu_data = $urandom;
        in_valid = $urandom_range(1, 0); in_data = $urandom;
        @(posedge clk); #1;
      end
      cpu_wrEn = 1'b0; in_valid = 1'b0;
      sweep("rand_sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
